// File: rtl/rggen_bit_field_if.sv
// Register-side access bundle shared by every bit field: the register block
// drives the access, the field answers with read data and its current value.
interface rggen_bit_field_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [WIDTH-1:0] read_mask;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] value;

    modport master (
        output valid, read_mask, write_mask, write_data,
        input  read_data, value
    );

    modport bit_field (
        input  valid, read_mask, write_mask, write_data,
        output read_data, value
    );
endinterface

// File: rtl/rggen_fifo_core.sv
// Count-based FIFO storage with wrap-around pointers for any DEPTH >= 2.
// Push/pop requests are qualified internally against full/empty; clear wins.
module rggen_fifo_core #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en;
    logic             pop_en;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];
    assign push_en = i_push && !o_full;
    assign pop_en  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop_en)  rd_ptr_d = next_ptr(rd_ptr_q);
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; the count alone decides which entries are
    // meaningful, so resetting the array would only cost a reset net per bit.
    always_ff @(posedge i_clk) begin
        if (push_en && !i_clear) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end
endmodule

// File: rtl/rggen_bit_field_rofifo.sv
// Read-only bit field: hardware pushes a stream, each software read returns
// and pops the oldest entry; reads of an empty FIFO flag an underflow.
module rggen_bit_field_rofifo #(
    parameter  int             WIDTH       = 8,
    parameter  int             DEPTH       = 4,
    parameter  bit [WIDTH-1:0] EMPTY_VALUE = '0,
    localparam int             CW          = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    rggen_bit_field_if.bit_field bit_field_if,
    input  logic               i_clear,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_data,
    output logic [CW-1:0]      o_count,
    output logic               o_empty,
    output logic               o_full,
    output logic               o_underflow
);
    logic             read_access;
    logic [WIDTH-1:0] head;
    logic             underflow_q, underflow_d;
    logic             unused_write;

    // Write accesses are accepted on the bus but carry no meaning here.
    assign unused_write = ^{bit_field_if.write_data, bit_field_if.write_mask};

    assign read_access = bit_field_if.valid && (|bit_field_if.read_mask);
    assign o_ready     = !o_full;
    assign o_underflow = underflow_q;

    rggen_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_core (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (i_clear),
        .i_push      (i_valid),
        .i_push_data (i_data),
        .i_pop       (read_access),
        .o_head      (head),
        .o_count     (o_count),
        .o_empty     (o_empty),
        .o_full      (o_full)
    );

    assign bit_field_if.read_data = o_empty ? EMPTY_VALUE : head;
    assign bit_field_if.value     = bit_field_if.read_data;

    always_comb begin
        underflow_d = read_access && o_empty && !i_clear;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end
endmodule

// File: tb/tb_rggen_bit_field_rofifo.sv
// Scoreboard bench: two instances (DEPTH 4 and DEPTH 3) share one stimulus
// stream; a queue-based reference model predicts every cycle's outputs.
module tb_rggen_bit_field_rofifo;
    localparam logic [7:0] EMPTY = 8'hEE;

    typedef struct packed {
        logic [7:0] rd;
        logic [2:0] count;
        logic       empty;
        logic       full;
        logic       ready;
        logic       uf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       valid;
    logic [7:0] data;
    logic       ready4, empty4, full4, uf4;
    logic       ready3, empty3, full3, uf3;
    logic [2:0] count4, count3;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mq  [2][$];
    exp_t       sbq [2][$];
    logic       muf [2];

    rggen_bit_field_if #(.WIDTH(8)) bf4 ();
    rggen_bit_field_if #(.WIDTH(8)) bf3 ();

    always #5 clk = ~clk;

    rggen_bit_field_rofifo #(.WIDTH(8), .DEPTH(4), .EMPTY_VALUE(EMPTY)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(bf4), .i_clear(clear),
        .i_valid(valid), .o_ready(ready4), .i_data(data), .o_count(count4),
        .o_empty(empty4), .o_full(full4), .o_underflow(uf4)
    );

    rggen_bit_field_rofifo #(.WIDTH(8), .DEPTH(3), .EMPTY_VALUE(EMPTY)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(bf3), .i_clear(clear),
        .i_valid(valid), .o_ready(ready3), .i_data(data), .o_count(count3),
        .o_empty(empty3), .o_full(full3), .o_underflow(uf3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the FIFO is just a queue bounded by depth.
    task automatic model_step(input int k, input logic v, input logic [7:0] d,
                              input logic clr, input logic rd);
        exp_t e;
        int   depth = (k == 0) ? 4 : 3;
        int   n     = mq[k].size();
        e.rd    = (n > 0) ? mq[k][0] : EMPTY;
        e.count = 3'(n);
        e.empty = (n == 0);
        e.full  = (n == depth);
        e.ready = (n != depth);
        e.uf    = muf[k];
        sbq[k].push_back(e);
        if (clr) begin
            mq[k].delete();
            muf[k] = 1'b0;
        end else begin
            muf[k] = rd && (n == 0);
            if (rd && n > 0) void'(mq[k].pop_front());
            if (v && n < depth) mq[k].push_back(d);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic clr,
                         input logic acc, input logic [7:0] rm, input logic [7:0] wm);
        @(posedge clk);
        #1;
        valid = v;
        data  = d;
        clear = clr;
        bf4.valid = acc; bf4.read_mask = rm; bf4.write_mask = wm; bf4.write_data = ~d;
        bf3.valid = acc; bf3.read_mask = rm; bf3.write_mask = wm; bf3.write_data = ~d;
        for (int k = 0; k < 2; k++) model_step(k, v, d, clr, acc && (rm != 8'h00));
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic push(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic read();
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 8 && (sbq[0].size() != 0 || sbq[1].size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        if (sbq[0].size() != 0 || sbq[1].size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d/%0d expectations left unchecked", sbq[0].size(), sbq[1].size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count4"}, 32'(count4), 0);
        check({tag, "_empty4"}, 32'(empty4), 1);
        check({tag, "_full4"},  32'(full4),  0);
        check({tag, "_ready4"}, 32'(ready4), 1);
        check({tag, "_uf4"},    32'(uf4),    0);
        check({tag, "_rdata4"}, 32'(bf4.read_data), 32'(EMPTY));
        check({tag, "_count3"}, 32'(count3), 0);
        check({tag, "_ready3"}, 32'(ready3), 1);
        check({tag, "_rdata3"}, 32'(bf3.value), 32'(EMPTY));
    endtask

    // Monitor: compare every presented cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq[0].size() != 0) begin
                e = sbq[0].pop_front();
                check("d4_read_data", 32'(bf4.read_data), 32'(e.rd));
                check("d4_value",     32'(bf4.value),     32'(e.rd));
                check("d4_count",     32'(count4),        32'(e.count));
                check("d4_empty",     32'(empty4),        32'(e.empty));
                check("d4_full",      32'(full4),         32'(e.full));
                check("d4_ready",     32'(ready4),        32'(e.ready));
                check("d4_underflow", 32'(uf4),           32'(e.uf));
            end
            if (sbq[1].size() != 0) begin
                e = sbq[1].pop_front();
                check("d3_read_data", 32'(bf3.read_data), 32'(e.rd));
                check("d3_value",     32'(bf3.value),     32'(e.rd));
                check("d3_count",     32'(count3),        32'(e.count));
                check("d3_empty",     32'(empty3),        32'(e.empty));
                check("d3_full",      32'(full3),         32'(e.full));
                check("d3_ready",     32'(ready3),        32'(e.ready));
                check("d3_underflow", 32'(uf3),           32'(e.uf));
            end
        end
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; valid = 1'b0; data = 8'h00;
        bf4.valid = 1'b0; bf4.read_mask = '0; bf4.write_mask = '0; bf4.write_data = '0;
        bf3.valid = 1'b0; bf3.read_mask = '0; bf3.write_mask = '0; bf3.write_data = '0;
        muf[0] = 1'b0; muf[1] = 1'b0;
        #23;
        check_reset_outputs("in_reset");
        rst_n = 1'b1;

        // Read straight out of reset: empty value, one underflow pulse.
        read();
        idle();
        idle();

        // Fill and drain (DEPTH 3 instance drops the fourth push).
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        idle();
        for (int i = 0; i < 5; i++) read();
        idle();

        // Simultaneous push and pop at count 2.
        push(8'h66); push(8'h77);
        cycle(1'b1, 8'h55, 1'b0, 1'b1, 8'h01, 8'h00);
        idle();
        for (int i = 0; i < 3; i++) read();
        idle();

        // Full with pop: push stalls while full, lands the next cycle.
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        cycle(1'b1, 8'h88, 1'b0, 1'b1, 8'hFF, 8'h00);
        push(8'h88);
        idle();
        for (int i = 0; i < 5; i++) read();

        // Wrap-around across many push/pop pairs, then a pure write access.
        for (int i = 0; i < 10; i++) begin
            push(8'($urandom));
            read();
        end
        push(8'h5A);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF);
        idle();
        read();

        // Clear at count 3 together with a push and a read.
        push(8'hC1); push(8'hC2); push(8'hC3);
        cycle(1'b1, 8'hC4, 1'b1, 1'b1, 8'hFF, 8'h00);
        idle();
        read();
        idle();

        // Asynchronous reset with entries held and a push in flight.
        push(8'hD1); push(8'hD2);
        idle();
        wait_drain();
        @(posedge clk);
        #1;
        valid = 1'b1; data = 8'hD3;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        mq[0].delete(); mq[1].delete();
        muf[0] = 1'b0; muf[1] = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b0;
        rst_n = 1'b1;
        idle();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic       v, clr, acc;
            logic [7:0] rm;
            v   = ($urandom_range(0, 99) < 55);
            clr = ($urandom_range(0, 99) < 3);
            acc = ($urandom_range(0, 99) < 45);
            rm  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cycle(v, 8'($urandom), clr, acc, rm, 8'($urandom));
        end
        idle();
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
